// File: rtl/uart_rx_timeout_fifo.sv
// UART receive FIFO with show-ahead read port, per-entry error flags,
// sticky overrun, trigger-level data-available and (optional) character
// timeout. Build with UART_RX_TIMEOUT_EN defined to include the timeout
// counter; without it charTimeout is tied low.
module uart_rx_timeout_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  baudRateX16Tick,
    input  logic [3:0]            charBits,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] pushData,
    input  logic [2:0]            pushFlags,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clearError,
    input  logic [DEPTH_LOG2:0]   triggerLevel,
    output logic [DATA_WIDTH-1:0] popData,
    output logic [2:0]            popFlags,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  fifoError,
    output logic                  dataAvailable,
    output logic                  charTimeout
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = DATA_WIDTH + 3;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [DEPTH_LOG2:0]   countReg;
    logic [DEPTH_LOG2:0]   errCount;
    logic [DEPTH_LOG2:0]   trigEff;
    logic                  doPush, doPop, overrunSet;
    logic                  pushFlagged, popFlagged;

    assign count = countReg;
    assign empty = (countReg == '0);
    assign full  = (countReg == FULL_COUNT);

    // Flush overrides both sides; a pop while full frees the slot the push needs.
    assign doPop       = pop && !empty && !flush;
    assign doPush      = push && (!full || doPop) && !flush;
    assign overrunSet  = push && full && !pop && !flush;
    assign pushFlagged = doPush && (pushFlags != 3'b000);
    assign popFlagged  = doPop && (popFlags != 3'b000);

    // Show-ahead: the head entry is always presented combinationally.
    assign {popFlags, popData} = mem[rdPtr];

    // A trigger level of zero behaves like one.
    assign trigEff       = (triggerLevel == '0) ? ONE_COUNT : triggerLevel;
    assign dataAvailable = (countReg >= trigEff);
    assign fifoError     = (errCount != '0);

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= {pushFlags, pushData};
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else if (flush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    // Number of stored entries carrying any error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            errCount <= '0;
        end else if (flush) begin
            errCount <= '0;
        end else begin
            case ({pushFlagged, popFlagged})
                2'b10:   errCount <= errCount + 1'b1;
                2'b01:   errCount <= errCount - 1'b1;
                default: errCount <= errCount;
            endcase
        end
    end

    // Sticky overrun; a new overrun wins over a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           overrun <= 1'b0;
        else if (overrunSet) overrun <= 1'b1;
        else if (clearError) overrun <= 1'b0;
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [9:0] toCount;
    logic [9:0] toInc;
    logic [9:0] toLimit;
    logic [3:0] charBitsEff;

    // Four character times = 64 x16-ticks per frame bit; zero means 10 bits.
    assign charBitsEff = (charBits == 4'd0) ? 4'd10 : charBits;
    assign toLimit     = {charBitsEff, 6'b000000};
    assign toInc       = (toCount == 10'h3FF) ? toCount : toCount + 1'b1;

    // Idle-time counter and timeout flag; any FIFO activity or emptiness restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            toCount     <= '0;
            charTimeout <= 1'b0;
        end else if (flush || push || pop || empty) begin
            toCount     <= '0;
            charTimeout <= 1'b0;
        end else if (baudRateX16Tick) begin
            toCount <= toInc;
            if (toInc >= toLimit) charTimeout <= 1'b1;
        end
    end
`else
    logic unusedTimeoutInputs;
    assign unusedTimeoutInputs = ^{baudRateX16Tick, charBits};
    assign charTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_timeout_fifo.sv
// Directed bench for uart_rx_timeout_fifo (DEPTH_LOG2=4, DATA_WIDTH=8).
module tb_uart_rx_timeout_fifo;
    logic       clock = 1'b0;
    logic       reset;
    logic       baudRateX16Tick;
    logic [3:0] charBits;
    logic       push;
    logic [7:0] pushData;
    logic [2:0] pushFlags;
    logic       pop;
    logic       flush;
    logic       clearError;
    logic [4:0] triggerLevel;
    logic [7:0] popData;
    logic [2:0] popFlags;
    logic       empty, full;
    logic [4:0] count;
    logic       overrun, fifoError, dataAvailable, charTimeout;

    int errCnt = 0;
    int chkCnt = 0;

    uart_rx_timeout_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .baudRateX16Tick(baudRateX16Tick),
        .charBits(charBits), .push(push), .pushData(pushData),
        .pushFlags(pushFlags), .pop(pop), .flush(flush),
        .clearError(clearError), .triggerLevel(triggerLevel),
        .popData(popData), .popFlags(popFlags), .empty(empty), .full(full),
        .count(count), .overrun(overrun), .fifoError(fifoError),
        .dataAvailable(dataAvailable), .charTimeout(charTimeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pushByte(input logic [7:0] d, input logic [2:0] f);
        push = 1'b1; pushData = d; pushFlags = f;
        step();
        push = 1'b0; pushFlags = 3'b000;
    endtask

    task automatic popOne();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; baudRateX16Tick = 1'b0; charBits = 4'd10;
        push = 1'b0; pushData = '0; pushFlags = '0; pop = 1'b0;
        flush = 1'b0; clearError = 1'b0; triggerLevel = '0;
        step();
        step();
        // Reset state
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_fifoError", 32'(fifoError), 0);
        chk("rst_dataAvail", 32'(dataAvailable), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_charTimeout", 32'(charTimeout), 0);
        reset = 1'b0;
        step();

        // Pop on empty ignored; push+pop on empty performs only the push
        popOne();
        chk("popEmpty_count", 32'(count), 0);
        push = 1'b1; pop = 1'b1; pushData = 8'h3C;
        step();
        push = 1'b0; pop = 1'b0;
        chk("pushPopEmpty_count", 32'(count), 1);
        chk("pushPopEmpty_data", 32'(popData), 32'h3C);
        popOne();
        chk("pushPopEmpty_drain", 32'(empty), 1);

        // Fill, overrun (set beats clear), drain in order
        for (int i = 0; i < 16; i++) pushByte(8'(i), 3'b000);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        chk("fill_overrun", 32'(overrun), 0);
        clearError = 1'b1;
        pushByte(8'hAA, 3'b000);
        clearError = 1'b0;
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(popData), 32'(i));
            popOne();
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_overrunSticky", 32'(overrun), 1);
        clearError = 1'b1;
        step();
        clearError = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) pushByte(8'(8'h10 + i), 3'b000);
        push = 1'b1; pop = 1'b1; pushData = 8'h55;
        step();
        push = 1'b0; pop = 1'b0;
        chk("fullPP_count", 32'(count), 16);
        chk("fullPP_overrun", 32'(overrun), 0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("fullPP_drain_%0d", i), 32'(popData), 32'(8'h11 + i));
            popOne();
        end
        chk("fullPP_last", 32'(popData), 32'h55);
        popOne();
        chk("fullPP_empty", 32'(empty), 1);

        // Error flag tracking
        pushByte(8'h41, 3'b010);
        pushByte(8'h42, 3'b000);
        chk("err_set", 32'(fifoError), 1);
        chk("err_headFlags", 32'(popFlags), 32'h2);
        popOne();
        chk("err_clear", 32'(fifoError), 0);
        chk("err_nextHead", 32'(popData), 32'h42);
        popOne();

        // Trigger level
        triggerLevel = 5'd4;
        for (int i = 0; i < 3; i++) pushByte(8'h60, 3'b000);
        chk("trig_below", 32'(dataAvailable), 0);
        pushByte(8'h63, 3'b000);
        chk("trig_at", 32'(dataAvailable), 1);
        flush = 1'b1; step(); flush = 1'b0;
        triggerLevel = 5'd0;
        chk("trig0_empty", 32'(dataAvailable), 0);
        pushByte(8'h64, 3'b000);
        chk("trig0_one", 32'(dataAvailable), 1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_empty", 32'(empty), 1);

        // Character timeout
        pushByte(8'h99, 3'b000);
        baudRateX16Tick = 1'b1;
        repeat (639) step();
        baudRateX16Tick = 1'b0;
        chk("to_639", 32'(charTimeout), 0);
        baudRateX16Tick = 1'b1;
        step();
        baudRateX16Tick = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
        chk("to_640", 32'(charTimeout), 1);
`else
        chk("to_disabled", 32'(charTimeout), 0);
`endif
        popOne();
        chk("to_popClear", 32'(charTimeout), 0);

        // Flush beats push
        for (int i = 0; i < 5; i++) pushByte(8'(8'h70 + i), 3'b100);
        chk("pre_flush_count", 32'(count), 5);
        flush = 1'b1; push = 1'b1; pushData = 8'hEE;
        step();
        flush = 1'b0; push = 1'b0;
        chk("flushPush_count", 32'(count), 0);
        chk("flushPush_empty", 32'(empty), 1);
        chk("flushPush_err", 32'(fifoError), 0);

        // Async reset mid-push, then push right after release
        pushByte(8'h01, 3'b000);
        pushByte(8'h02, 3'b000);
        push = 1'b1; pushData = 8'h03;
        #2 reset = 1'b1;
        #1;
        chk("asyncRst_empty", 32'(empty), 1);
        chk("asyncRst_count", 32'(count), 0);
        pushData = 8'h77;
        #1 reset = 1'b0;
        step();
        push = 1'b0;
        chk("postRst_count", 32'(count), 1);
        chk("postRst_data", 32'(popData), 32'h77);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule

// File: doc/uart_rx_timeout_fifo.md
UART_RX_TIMEOUT_FIFO -- requirements
Module: uart_rx_timeout_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth is 2^DEPTH_LOG2 entries (legal range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per entry (legal range 5..9).
REQ-003 SHALL have port clock, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port baudRateX16Tick, input, 1, one-cycle pulse at 16x baud.
REQ-006 SHALL have port charBits, input, 4, frame length in bits (start+data+parity+stop).
REQ-007 SHALL have port push, input, 1, write request from the receiver.
REQ-008 SHALL have port pushData, input, DATA_WIDTH, received character.
REQ-009 SHALL have port pushFlags, input, 3, {break, frameError, parityError} for pushData.
REQ-010 SHALL have port pop, input, 1, read request from the bus side.
REQ-011 SHALL have port flush, input, 1, synchronous FIFO clear.
REQ-012 SHALL have port clearError, input, 1, clears sticky overrun.
REQ-013 SHALL have port triggerLevel, input, DEPTH_LOG2+1, data-available threshold.
REQ-014 SHALL have port popData, output, DATA_WIDTH, head entry payload (show-ahead).
REQ-015 SHALL have port popFlags, output, 3, head entry flags.
REQ-016 SHALL have ports empty, full, output, 1 each, occupancy status.
REQ-017 SHALL have port count, output, DEPTH_LOG2+1, current entry count 0..2^DEPTH_LOG2.
REQ-018 SHALL have ports overrun, fifoError, dataAvailable, charTimeout, output, 1 each.

Function
REQ-019 SHALL store {pushFlags, pushData} at the write pointer on push when not full, visible on popData/popFlags in the next cycle if the FIFO was empty.
REQ-020 SHALL advance the read pointer on pop when not empty; pop when empty is ignored.
REQ-021 SHALL wrap both pointers modulo 2^DEPTH_LOG2 without reset of the stored data.
REQ-022 SHALL, on push while full without simultaneous pop, drop the data and set overrun (sticky).
REQ-023 SHALL, on push and pop in the same cycle while full, perform both; count unchanged, no overrun.
REQ-024 SHALL, on push and pop in the same cycle while empty, perform only the push; count becomes 1.
REQ-025 SHALL give flush priority over push and pop: pointers, count, error counter and charTimeout cleared next edge; overrun not affected.
REQ-026 SHALL clear overrun on clearError; overrun setting in the same cycle wins over clearError.
REQ-027 SHALL keep an internal counter of entries with any nonzero flag; fifoError = (counter != 0); increment/decrement on push/pop of flagged entries, both in one cycle leaves it unchanged.
REQ-028 SHALL drive dataAvailable = (count >= max(triggerLevel,1)), combinational from registered count.
REQ-029 SHALL run a timeout counter of baudRateX16Tick pulses, cleared on push, pop, flush or when empty.
REQ-030 SHALL set charTimeout when count != 0 and the counter reaches 64*charBits (4 character times); held until push, pop or flush.
REQ-031 SHALL size the timeout counter to 10 bits and saturate, never wrap.
REQ-032 SHALL treat charBits = 0 as 10.

Reset
REQ-033 SHALL on reset asynchronously clear pointers, count, error counter, timeout counter, overrun and charTimeout; empty=1, full=0, fifoError=0, dataAvailable=0; popData/popFlags undefined content need not be cleared.
REQ-034 SHALL, if reset asserts mid-operation, discard all stored entries and accept push on the first edge after release.

Configuration
REQ-035 SHALL, with UART_RX_TIMEOUT_EN defined, implement REQ-029..REQ-032.
REQ-036 SHALL, without UART_RX_TIMEOUT_EN, omit the timeout counter and tie charTimeout to 0; baudRateX16Tick and charBits unused.

Verification (DEPTH_LOG2=4, DATA_WIDTH=8)
REQ-037 SHALL cover: push 16 bytes 0x00..0x0F -> full=1, count=16; 17th push 0xAA -> dropped, overrun=1; 16 pops return 0x00..0x0F then empty=1.
REQ-038 SHALL cover: FIFO full, push 0x55 with pop same cycle -> count stays 16, overrun=0, last pop after drain returns 0x55.
REQ-039 SHALL cover: push 0x41 flags=3'b010, push 0x42 flags=0 -> fifoError=1; pop once -> fifoError=0.
REQ-040 SHALL cover: triggerLevel=4, push 3 -> dataAvailable=0; 4th push -> dataAvailable=1; triggerLevel=0, count=1 -> dataAvailable=1.
REQ-041 SHALL cover: UART_RX_TIMEOUT_EN, charBits=10, one entry, 639 ticks -> charTimeout=0, 640th tick -> 1; pop -> 0 next cycle.
REQ-042 SHALL cover: 5 entries, flush and push same cycle -> count=0, empty=1; reset pulse mid-push -> empty=1 immediately.
